guess_input_capture: RTL and testbench



---
 rtl/guess_input_capture.sv | 164 ++++++++++++++++
 tb/tb_guess_input_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/guess_input_capture.sv
// Hangman guess front end: debounced key press samples the letter switches.
// Optional used-letter tracking enabled by defining GUESS_USED_MASK_EN.
module guess_input_capture #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       key_n_i,
   input  logic [4:0] sw_i,
   input  logic       new_round_i,
   input  logic       guess_ready_i,
   output logic       guess_valid_o,
   output logic [4:0] guess_letter_o,
   output logic       invalid_pulse_o,
   output logic       overrun_pulse_o,
   output logic       repeat_pulse_o,
   output logic       busy_o
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_meta_q, key_s_q;
   logic [4:0]       sw_meta_q, sw_s_q;
   logic             valid_q, valid_d;
   logic [4:0]       letter_q, letter_d;
   logic             inv_q, ovr_q, rep_q;
   logic             capture, freed, bad_code, overrun, repeat_hit, load;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         key_meta_q <= 1'b1;
         key_s_q    <= 1'b1;
         sw_meta_q  <= '0;
         sw_s_q     <= '0;
      end else begin
         key_meta_q <= key_n_i;
         key_s_q    <= key_meta_q;
         sw_meta_q  <= sw_i;
         sw_s_q     <= sw_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!key_s_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (key_s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               cnt_d   = '0;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (key_s_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!key_s_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A slot freed by a transfer at this edge may be refilled at the same edge
   assign freed    = valid_q & guess_ready_i;
   assign bad_code = capture & (sw_s_q > 5'd25);
   assign overrun  = capture & ~bad_code & valid_q & ~freed;
   assign load     = capture & ~bad_code & ~overrun & ~repeat_hit;

`ifdef GUESS_USED_MASK_EN
   logic [25:0] mask_q, mask_d, mask_eff;

   assign mask_eff   = new_round_i ? '0 : mask_q;
   assign repeat_hit = capture & ~bad_code & ~overrun & mask_eff[sw_s_q];
   assign mask_d     = load ? (mask_eff | (26'd1 << sw_s_q)) : mask_eff;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) mask_q <= '0;
      else         mask_q <= mask_d;
   end
`else
   logic unused_new_round;

   assign unused_new_round = new_round_i;
   assign repeat_hit       = 1'b0;
`endif

   always_comb begin
      valid_d  = load | (valid_q & ~freed);
      letter_d = load ? sw_s_q : letter_q;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         letter_q <= '0;
         inv_q    <= 1'b0;
         ovr_q    <= 1'b0;
         rep_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         letter_q <= letter_d;
         inv_q    <= bad_code;
         ovr_q    <= overrun;
         rep_q    <= repeat_hit;
      end
   end

   assign guess_valid_o   = valid_q;
   assign guess_letter_o  = letter_q;
   assign invalid_pulse_o = inv_q;
   assign overrun_pulse_o = ovr_q;
   assign busy_o          = (state_q != IDLE);

`ifdef GUESS_USED_MASK_EN
   assign repeat_pulse_o = rep_q;
`else
   logic unused_rep;

   assign unused_rep     = rep_q;
   assign repeat_pulse_o = 1'b0;
`endif

endmodule

// File: tb/tb_guess_input_capture.sv
// Scoreboard bench for guess_input_capture with a short debounce window.
// Covers GUESS_USED_MASK_EN when the macro is defined for the build.
module tb_guess_input_capture;

   localparam int D = 4;

   localparam int K_LOAD = 0;
   localparam int K_INV  = 1;
   localparam int K_OVR  = 2;
   localparam int K_REP  = 3;

   typedef struct {
      int         kind;
      logic [4:0] letter;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_n;
   logic [4:0] sw;
   logic       new_round;
   logic       ready;
   logic       valid;
   logic [4:0] letter;
   logic       inv_p, ovr_p, rep_p, busy;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   guess_input_capture #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(8)
   ) dut (
      .clock_i        (clk),
      .reset_i        (rst),
      .key_n_i        (key_n),
      .sw_i           (sw),
      .new_round_i    (new_round),
      .guess_ready_i  (ready),
      .guess_valid_o  (valid),
      .guess_letter_o (letter),
      .invalid_pulse_o(inv_p),
      .overrun_pulse_o(ovr_p),
      .repeat_pulse_o (rep_p),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic got(input int kind, input logic [4:0] l);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected event: kind %0d letter %0d at cycle %0d", kind, l, cyc);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.cyc != cyc || (kind == K_LOAD && e.letter != l)) begin
            errors++;
            $display("FAIL event: got kind %0d letter %0d cycle %0d, expected kind %0d letter %0d cycle %0d",
                     kind, l, cyc, e.kind, e.letter, e.cyc);
         end
      end
   endtask

   // monitor: samples 1 time unit after each rising edge
   initial begin
      logic vprev;
      vprev = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!rst) begin
            if (valid && (!vprev || ready)) got(K_LOAD, letter);
            if (inv_p) got(K_INV, 5'd0);
            if (ovr_p) got(K_OVR, 5'd0);
            if (rep_p) got(K_REP, 5'd0);
         end
         vprev = valid;
      end
   end

   task automatic press(input logic [4:0] code, input int kind, input bit rdy_at_cap);
      int cap;
      @(negedge clk);
      key_n = 1'b0;
      sw    = code;
      cap   = cyc + 1 + D + 2;
      q.push_back('{kind, code, cap});
      repeat (D + 4) begin
         @(negedge clk);
         if (rdy_at_cap && cyc + 1 == cap) ready = 1'b1;
      end
   endtask

   task automatic release_key();
      @(negedge clk);
      key_n = 1'b1;
      repeat (D + 6) @(negedge clk);
      chk("busy after release", int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1; key_n = 1'b1; sw = '0; new_round = 1'b0; ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset valid", int'(valid), 0);
      chk("reset letter", int'(letter), 0);
      chk("reset inv", int'(inv_p), 0);
      chk("reset ovr", int'(ovr_p), 0);
      chk("reset rep", int'(rep_p), 0);
      chk("reset busy", int'(busy), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic accepted press, consumed immediately
      ready = 1'b1;
      press(5'd7, K_LOAD, 1'b0);
      chk("valid cleared by transfer", int'(valid), 0);
      chk("busy while held", int'(busy), 1);
      release_key();

      // three short bounces: no capture
      for (int i = 0; i < 3; i++) begin
         key_n = 1'b0; sw = 5'd11;
         repeat (3) @(negedge clk);
         key_n = 1'b1;
         repeat (3) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("busy after bounces", int'(busy), 0);
      chk("valid after bounces", int'(valid), 0);

      // range boundaries
      press(5'd30, K_INV, 1'b0);
      chk("valid after code 30", int'(valid), 0);
      release_key();
      press(5'd25, K_LOAD, 1'b0);
      release_key();
      press(5'd26, K_INV, 1'b0);
      release_key();

      // overrun while pending, then refill at the transfer edge
      ready = 1'b0;
      press(5'd2, K_LOAD, 1'b0);
      release_key();
      press(5'd5, K_OVR, 1'b0);
      chk("pending letter kept", int'(letter), 2);
      chk("pending valid kept", int'(valid), 1);
      release_key();
      press(5'd9, K_LOAD, 1'b1);
      release_key();
      chk("valid after refill drained", int'(valid), 0);

      // reset mid PRESS_WAIT
      ready = 1'b0;
      @(negedge clk);
      key_n = 1'b0; sw = 5'd3;
      repeat (4) @(negedge clk);
      chk("busy in press wait", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("busy on reset", int'(busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q.push_back('{K_LOAD, 5'd3, cyc + 1 + D + 2});
      repeat (D + 4) @(negedge clk);
      chk("valid after requalify", int'(valid), 1);
      chk("letter after requalify", int'(letter), 3);

      // reset with a guess pending
      rst = 1'b1;
      #1;
      chk("valid on reset", int'(valid), 0);
      chk("letter on reset", int'(letter), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q.push_back('{K_LOAD, 5'd3, cyc + 1 + D + 2});
      repeat (D + 4) @(negedge clk);
      chk("valid after second reset", int'(valid), 1);
      ready = 1'b1;
      release_key();

      // repeated letter
      press(5'd4, K_LOAD, 1'b0);
      release_key();
`ifdef GUESS_USED_MASK_EN
      press(5'd4, K_REP, 1'b0);
      chk("valid after repeat", int'(valid), 0);
      release_key();
      new_round = 1'b1;
      @(negedge clk);
      new_round = 1'b0;
      press(5'd4, K_LOAD, 1'b0);
      release_key();
`else
      new_round = 1'b1;
      @(negedge clk);
      new_round = 1'b0;
      press(5'd4, K_LOAD, 1'b0);
      release_key();
`endif

      repeat (10) @(negedge clk);
      chk("scoreboard drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
